// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one outstanding imem request at a time,
// and buffers up to two {pc, inst} pairs for the core behind a valid/ready handshake.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // request valid may only be withdrawn unaccepted when a redirect arrives.
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        pend_q, pend_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] pc_mem_q [2];
    logic [31:0] pc_mem_d [2];
    logic [31:0] inst_mem_q [2];
    logic [31:0] inst_mem_d [2];

    logic req_fire;
    logic pop;
    logic push;

    assign imem_req_valid = !rst && (state_q == ST_REQ) && (count_q < 2'd2);
    assign imem_req_addr  = fetch_pc_q;
    assign inst_valid     = (count_q != 2'd0);
    assign inst           = inst_mem_q[rd_ptr_q];
    assign inst_pc        = pc_mem_q[rd_ptr_q];

    assign req_fire = imem_req_valid && imem_req_ready;
    assign pop      = inst_valid && inst_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        pend_d     = pend_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        push       = 1'b0;

        case (state_q)
            ST_REQ: begin
                if (req_fire) begin
                    pend_d     = 1'b1;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    push    = 1'b1;
                    pend_d  = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_FLUSH: begin
                if (imem_rsp_valid) begin
                    pend_d  = 1'b0;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        if (redirect_valid) begin
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            // A response landing in the redirect cycle retires the old request itself,
            // so only a still-unanswered or freshly accepted request needs FLUSH.
            if ((pend_q && !imem_rsp_valid) || req_fire) begin
                state_d = ST_FLUSH;
                pend_d  = 1'b1;
            end else begin
                state_d = ST_REQ;
                pend_d  = 1'b0;
            end
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]   = req_pc_q;
                inst_mem_d[wr_ptr_q] = imem_rsp_data;
                wr_ptr_d             = !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = !rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= 32'd0;
            pend_q     <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            pc_mem_q   <= '{default: 32'd0};
            inst_mem_q <= '{default: 32'd0};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            pend_q     <= pend_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: behavioural imem returning the address complement,
// consumer scoreboard on popped instructions, and cycle-exact directed checks.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        man_rsp_valid;
    logic [31:0] man_rsp_data;
    logic        mem_auto;
    int          mem_lat;
    logic [31:0] mem_addr;

    int          n_checks;
    int          n_errors;
    int          req_cnt;
    int          req_base;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    assign imem_rsp_valid = mem_rsp_valid | man_rsp_valid;
    assign imem_rsp_data  = man_rsp_valid ? man_rsp_data : mem_rsp_data;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // memory model: answers an accepted request mem_lat cycles later with ~addr
    initial begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_auto && imem_req_valid && imem_req_ready) begin
                mem_addr = imem_req_addr;
                repeat (mem_lat) @(posedge clk);
                #1;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = ~mem_addr;
                @(posedge clk);
                #1;
                mem_rsp_valid = 1'b0;
            end
        end
    end

    // request counter and consumer scoreboard
    initial req_cnt = 0;
    always @(negedge clk) begin
        if (imem_req_valid && imem_req_ready) req_cnt++;
        if (inst_valid && inst_ready) begin
            check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_pc = exp_q.pop_front();
                check("pop_pc", inst_pc, exp_pc);
                check("pop_inst", inst, ~exp_pc);
            end
        end
    end

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        man_rsp_valid  = 1'b0;
        man_rsp_data   = 32'd0;
        mem_auto       = 1'b1;
        mem_lat        = 1;

        // reset values and streaming with a 1-cycle memory
        tick();
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h8000_0000);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        rst = 1'b0;
        #1;
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(32'h8000_0004);
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h8000_0000);
        tick();
        check("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("wait_inst_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("s1_inst_valid", {31'd0, inst_valid}, 32'd1);
        check("s1_inst_pc", inst_pc, 32'h8000_0000);
        check("s1_inst", inst, 32'h7FFF_FFFF);
        check("s1_req_addr", imem_req_addr, 32'h8000_0004);
        tick();
        tick();
        check("s2_inst_pc", inst_pc, 32'h8000_0004);
        check("s2_inst", inst, 32'h7FFF_FFFB);
        check("s2_req_addr", imem_req_addr, 32'h8000_0008);
        tick();

        // back-pressure: only two requests may be issued
        inst_ready = 1'b0;
        do_reset();
        req_base = req_cnt;
        repeat (10) tick();
        check("bp_req_count", 32'(req_cnt - req_base), 32'd2);
        check("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("bp_inst_valid", {31'd0, inst_valid}, 32'd1);
        check("bp_inst_pc", inst_pc, 32'h8000_0000);
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(32'h8000_0004);
        inst_ready = 1'b1;
        tick();
        check("bp_next_pc", inst_pc, 32'h8000_0004);
        check("bp_resume_valid", {31'd0, imem_req_valid}, 32'd1);
        check("bp_resume_addr", imem_req_addr, 32'h8000_0008);
        mem_lat = 2;

        // redirect while waiting on a slow response
        tick();
        check("rw_req_valid", {31'd0, imem_req_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1003;
        tick();
        redirect_valid = 1'b0;
        check("rw_flush_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rw_flush_inst_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("rw_req_valid2", {31'd0, imem_req_valid}, 32'd1);
        check("rw_req_addr", imem_req_addr, 32'h0000_1000);
        check("rw_inst_valid", {31'd0, inst_valid}, 32'd0);
        mem_lat = 1;
        exp_q.push_back(32'h0000_1000);
        tick();
        tick();
        check("rw_deliver_pc", inst_pc, 32'h0000_1000);
        check("rw_deliver_inst", inst, 32'hFFFF_EFFF);
        check("rw_deliver_addr", imem_req_addr, 32'h0000_1004);

        // redirect coinciding with request accept and a consumer pop
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        tick();
        redirect_valid = 1'b0;
        check("ra_flush_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("ra_inst_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("ra_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("ra_req_addr", imem_req_addr, 32'h0000_2000);
        check("ra_pop_counted", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(32'h0000_2000);
        tick();
        tick();
        check("ra_deliver_pc", inst_pc, 32'h0000_2000);
        check("ra_deliver_inst", inst, 32'hFFFF_DFFF);

        // address wrap at the top of the space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        tick();
        tick();
        check("wrap_top_pc", inst_pc, 32'hFFFF_FFFC);
        check("wrap_top_inst", inst, 32'h0000_0003);
        check("wrap_next_addr", imem_req_addr, 32'h0000_0000);
        exp_q.push_back(32'h0000_0000);
        tick();
        tick();
        check("wrap_zero_pc", inst_pc, 32'h0000_0000);
        check("wrap_zero_inst", inst, 32'hFFFF_FFFF);

        // reset with a request outstanding, then a stale response after release
        tick();
        inst_ready = 1'b0;
        tick();
        mem_auto = 1'b0;
        tick();
        check("mr_pre_inst_pc", inst_pc, 32'h0000_0004);
        check("mr_pre_req_valid", {31'd0, imem_req_valid}, 32'd0);
        rst = 1'b1;
        #1;
        check("mr_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("mr_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("mr_rst_req_addr", imem_req_addr, 32'h8000_0000);
        tick();
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        man_rsp_valid  = 1'b1;
        man_rsp_data   = 32'hDEAD_BEEF;
        #1;
        check("mr_rel_req_valid", {31'd0, imem_req_valid}, 32'd1);
        tick();
        man_rsp_valid = 1'b0;
        check("mr_no_push", {31'd0, inst_valid}, 32'd0);
        check("mr_req_addr", imem_req_addr, 32'h8000_0000);
        imem_req_ready = 1'b1;
        mem_auto       = 1'b1;
        inst_ready     = 1'b1;
        exp_q.push_back(32'h8000_0000);
        tick();
        tick();
        check("mr_deliver_pc", inst_pc, 32'h8000_0000);
        check("mr_deliver_inst", inst, 32'h7FFF_FFFF);
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
